// File: rtl/stack_queue_buf_pkg.sv
// Shared constants and width helpers for the stack/queue buffer.
// Imported by the top and used to size its count and pointer ports.
package stack_queue_buf_pkg;

   localparam logic MODE_FIFO = 1'b0;
   localparam logic MODE_LIFO = 1'b1;

   // Occupancy needs to represent 0..DEPTH inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/buf_mem.sv
// DEPTH x WIDTH storage: one synchronous write port and one registered read port.
// Only the read register is reset; the array itself is left uninitialised.
module buf_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // NOTE: the array has no reset so it can map onto RAM; stale contents are never read because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // NOTE: non-blocking assignments make a read on the same edge as a write to that slot return the old word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/stack_queue_buf.sv
// Run-time selectable LIFO/FIFO buffer with registered read port, occupancy flags
// and sticky overflow/underflow errors.
module stack_queue_buf
   import stack_queue_buf_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          mode,
   input  logic                          push,
   input  logic                          pop,
   input  logic [WIDTH-1:0]              data_in,
   input  logic                          err_clr,
   output logic [WIDTH-1:0]              data_out,
   output logic                          out_valid,
   output logic [count_width(DEPTH)-1:0] count,
   output logic                          empty,
   output logic                          full,
   output logic                          almost_full,
   output logic                          active_mode,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int CW = count_width(DEPTH);
   localparam int AW = ptr_width(DEPTH);

   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic          empty_q, empty_d, full_q, full_d, af_q, af_d;
   logic          mode_q, mode_d, ovf_q, ovf_d, udf_q, udf_d, valid_q;
   logic          pop_ok, push_ok;
   logic [AW-1:0] waddr, raddr, top_idx;

   // Compare-to-last wrap keeps non-power-of-2 depths correct.
   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      pop_ok   = pop & ~empty_q;
      push_ok  = push & (~full_q | pop_ok);
      top_idx  = AW'(count_q - CW'(1));
      waddr    = wr_ptr_q;
      raddr    = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (mode_q == MODE_LIFO) begin
         raddr = top_idx;
         waddr = pop_ok ? top_idx : AW'(count_q);
      end else begin
         if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
         if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
      end

      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CW'(1);

      empty_d = (count_d == '0);
      full_d  = (count_d == CW'(DEPTH));
      af_d    = (count_d >= CW'(AF_LEVEL));

      // Mode only switches while nothing is stored, so data is never reordered.
      mode_d = (empty_q && !push_ok) ? mode : mode_q;
      ovf_d  = (ovf_q & ~err_clr) | (push & ~push_ok);
      udf_d  = (udf_q & ~err_clr) | (pop & ~pop_ok);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         af_q     <= 1'b0;
         mode_q   <= MODE_FIFO;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         af_q     <= af_d;
         mode_q   <= mode_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         valid_q  <= pop_ok;
      end
   end

   buf_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (push_ok),
      .waddr_i (waddr),
      .wdata_i (data_in),
      .re_i    (pop_ok),
      .raddr_i (raddr),
      .rdata_o (data_out)
   );

   assign out_valid   = valid_q;
   assign count       = count_q;
   assign empty       = empty_q;
   assign full        = full_q;
   assign almost_full = af_q;
   assign active_mode = mode_q;
   assign overflow    = ovf_q;
   assign underflow   = udf_q;

endmodule

// File: tb/tb_stack_queue_buf.sv
// Table-driven bench for stack_queue_buf (WIDTH=8, DEPTH=4, AF_LEVEL=3) with a
// read-data scoreboard and a hand-written asynchronous reset sequence.
module tb_stack_queue_buf;

   localparam int WIDTH    = 8;
   localparam int DEPTH    = 4;
   localparam int AF_LEVEL = 3;
   localparam int CW       = 3;

   logic             clk, rst, mode, push, pop, err_clr;
   logic [WIDTH-1:0] data_in, data_out;
   logic             out_valid, empty, full, almost_full, active_mode, overflow, underflow;
   logic [CW-1:0]    count;

   stack_queue_buf #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mode        (mode),
      .push        (push),
      .pop         (pop),
      .data_in     (data_in),
      .err_clr     (err_clr),
      .data_out    (data_out),
      .out_valid   (out_valid),
      .count       (count),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .active_mode (active_mode),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       push, pop, mode, clr;
      logic [7:0] din;
      logic       exp_rd;
      logic [7:0] exp_dat;
      int         exp_cnt;
      logic       exp_mode, exp_ovf, exp_udf;
   } vec_t;

   vec_t       tbl_a[$];
   vec_t       tbl_b[$];
   logic [7:0] sb[$];
   logic [7:0] last_data;
   int         n_checks;
   int         n_errors;

   function automatic vec_t v(input logic pu, po, md, clr, input logic [7:0] din,
                              input logic rd, input logic [7:0] rdat, input int cnt,
                              input logic am, ov, ud);
      vec_t r;
      r.push = pu;  r.pop = po;  r.mode = md;  r.clr = clr;  r.din = din;
      r.exp_rd = rd; r.exp_dat = rdat; r.exp_cnt = cnt;
      r.exp_mode = am; r.exp_ovf = ov; r.exp_udf = ud;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t t, input string tag, input int idx);
      logic [7:0] e;
      @(negedge clk);
      push = t.push; pop = t.pop; mode = t.mode; err_clr = t.clr; data_in = t.din;
      if (t.exp_rd) sb.push_back(t.exp_dat);
      @(posedge clk);
      #1;
      check($sformatf("%s%0d count", tag, idx), 32'(count), 32'(t.exp_cnt));
      check($sformatf("%s%0d empty", tag, idx), 32'(empty), 32'(t.exp_cnt == 0));
      check($sformatf("%s%0d full", tag, idx), 32'(full), 32'(t.exp_cnt == DEPTH));
      check($sformatf("%s%0d almost_full", tag, idx), 32'(almost_full), 32'(t.exp_cnt >= AF_LEVEL));
      check($sformatf("%s%0d active_mode", tag, idx), 32'(active_mode), 32'(t.exp_mode));
      check($sformatf("%s%0d overflow", tag, idx), 32'(overflow), 32'(t.exp_ovf));
      check($sformatf("%s%0d underflow", tag, idx), 32'(underflow), 32'(t.exp_udf));
      check($sformatf("%s%0d out_valid", tag, idx), 32'(out_valid), 32'(t.exp_rd));
      if (out_valid) begin
         if (sb.size() == 0) begin
            check($sformatf("%s%0d unexpected valid", tag, idx), 32'(out_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            check($sformatf("%s%0d data_out", tag, idx), 32'(data_out), 32'(e));
            last_data = e;
         end
      end else begin
         check($sformatf("%s%0d data_hold", tag, idx), 32'(data_out), 32'(last_data));
      end
   endtask

   initial begin
      n_checks = 0; n_errors = 0; last_data = '0;
      rst = 1'b1; mode = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; data_in = '0;

      // FIFO fill then drain
      tbl_a.push_back(v(1,0,0,0,8'h11,0,8'h00,1,0,0,0));
      tbl_a.push_back(v(1,0,0,0,8'h22,0,8'h00,2,0,0,0));
      tbl_a.push_back(v(1,0,0,0,8'h33,0,8'h00,3,0,0,0));
      tbl_a.push_back(v(1,0,0,0,8'h44,0,8'h00,4,0,0,0));
      tbl_a.push_back(v(0,1,0,0,8'h00,1,8'h11,3,0,0,0));
      tbl_a.push_back(v(0,1,0,0,8'h00,1,8'h22,2,0,0,0));
      tbl_a.push_back(v(0,1,0,0,8'h00,1,8'h33,1,0,0,0));
      tbl_a.push_back(v(0,1,0,0,8'h00,1,8'h44,0,0,0,0));
      // LIFO basic
      tbl_a.push_back(v(0,0,1,0,8'h00,0,8'h00,0,1,0,0));
      tbl_a.push_back(v(1,0,1,0,8'hA1,0,8'h00,1,1,0,0));
      tbl_a.push_back(v(1,0,1,0,8'hA2,0,8'h00,2,1,0,0));
      tbl_a.push_back(v(1,0,1,0,8'hA3,0,8'h00,3,1,0,0));
      tbl_a.push_back(v(0,1,1,0,8'h00,1,8'hA3,2,1,0,0));
      tbl_a.push_back(v(0,1,1,0,8'h00,1,8'hA2,1,1,0,0));
      tbl_a.push_back(v(0,1,1,0,8'h00,1,8'hA1,0,1,0,0));
      // LIFO full with simultaneous push+pop
      for (int i = 1; i <= 4; i++) tbl_a.push_back(v(1,0,1,0,8'(i),0,8'h00,i,1,0,0));
      tbl_a.push_back(v(1,1,1,0,8'h55,1,8'h04,4,1,0,0));
      tbl_a.push_back(v(0,1,1,0,8'h00,1,8'h55,3,1,0,0));
      tbl_a.push_back(v(0,1,1,0,8'h00,1,8'h03,2,1,0,0));
      tbl_a.push_back(v(0,1,1,0,8'h00,1,8'h02,1,1,0,0));
      tbl_a.push_back(v(0,1,1,0,8'h00,1,8'h01,0,1,0,0));
      // Errors
      tbl_a.push_back(v(0,1,1,0,8'h00,0,8'h00,0,1,0,1));
      tbl_a.push_back(v(1,1,1,0,8'h77,0,8'h00,1,1,0,1));
      tbl_a.push_back(v(1,0,1,0,8'h78,0,8'h00,2,1,0,1));
      tbl_a.push_back(v(1,0,1,0,8'h79,0,8'h00,3,1,0,1));
      tbl_a.push_back(v(1,0,1,0,8'h7A,0,8'h00,4,1,0,1));
      tbl_a.push_back(v(1,0,1,0,8'h99,0,8'h00,4,1,1,1));
      tbl_a.push_back(v(0,1,1,0,8'h00,1,8'h7A,3,1,1,1));
      tbl_a.push_back(v(0,0,1,1,8'h00,0,8'h00,3,1,0,0));
      tbl_a.push_back(v(0,1,1,0,8'h00,1,8'h79,2,1,0,0));
      tbl_a.push_back(v(0,1,1,0,8'h00,1,8'h78,1,1,0,0));
      tbl_a.push_back(v(0,1,1,0,8'h00,1,8'h77,0,1,0,0));
      tbl_a.push_back(v(0,1,1,1,8'h00,0,8'h00,0,1,0,1));
      tbl_a.push_back(v(0,0,1,1,8'h00,0,8'h00,0,1,0,0));
      // FIFO wrap under concurrent push+pop at count=2
      tbl_a.push_back(v(0,0,0,0,8'h00,0,8'h00,0,0,0,0));
      tbl_a.push_back(v(1,0,0,0,8'h01,0,8'h00,1,0,0,0));
      tbl_a.push_back(v(1,0,0,0,8'h02,0,8'h00,2,0,0,0));
      for (int i = 0; i < 10; i++) tbl_a.push_back(v(1,1,0,0,8'(3 + i),1,8'(1 + i),2,0,0,0));
      // Mode lock while occupied
      tbl_a.push_back(v(0,0,1,0,8'h00,0,8'h00,2,0,0,0));
      tbl_a.push_back(v(0,1,1,0,8'h00,1,8'h0B,1,0,0,0));
      tbl_a.push_back(v(0,1,0,0,8'h00,1,8'h0C,0,0,0,0));
      // Build up LIFO state with an error pending before the reset
      tbl_a.push_back(v(0,0,1,0,8'h00,0,8'h00,0,1,0,0));
      for (int i = 1; i <= 4; i++) tbl_a.push_back(v(1,0,1,0,8'(8'h20 + i),0,8'h00,i,1,0,0));
      tbl_a.push_back(v(1,0,1,0,8'h25,0,8'h00,4,1,1,0));
      tbl_a.push_back(v(0,1,1,0,8'h00,1,8'h24,3,1,1,0));
      // After reset: storage still usable
      tbl_b.push_back(v(1,0,0,0,8'h5A,0,8'h00,1,0,0,0));
      tbl_b.push_back(v(1,0,0,0,8'h5B,0,8'h00,2,0,0,0));
      tbl_b.push_back(v(0,1,0,0,8'h00,1,8'h5A,1,0,0,0));

      repeat (2) @(posedge clk);
      #1;
      check("reset count", 32'(count), 32'd0);
      check("reset empty", 32'(empty), 32'd1);
      check("reset full", 32'(full), 32'd0);
      check("reset almost_full", 32'(almost_full), 32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset data_out", 32'(data_out), 32'd0);
      check("reset active_mode", 32'(active_mode), 32'd0);
      check("reset overflow", 32'(overflow), 32'd0);
      check("reset underflow", 32'(underflow), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tbl_a.size(); i++) apply(tbl_a[i], "a", i);

      // Asynchronous reset between clock edges while out_valid is high
      #2;
      rst = 1'b1; push = 1'b0; pop = 1'b0; mode = 1'b0; err_clr = 1'b0;
      #1;
      check("async count", 32'(count), 32'd0);
      check("async empty", 32'(empty), 32'd1);
      check("async full", 32'(full), 32'd0);
      check("async almost_full", 32'(almost_full), 32'd0);
      check("async out_valid", 32'(out_valid), 32'd0);
      check("async data_out", 32'(data_out), 32'd0);
      check("async active_mode", 32'(active_mode), 32'd0);
      check("async overflow", 32'(overflow), 32'd0);
      last_data = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tbl_b.size(); i++) apply(tbl_b[i], "b", i);
      check("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/stack_queue_buf.md
Name: stack_queue_buf

Overview:
- Parametrised single-clock buffer that runs as either a LIFO (stack) or a FIFO (queue); mode is selectable at run time.
- Next-generation replacement for the team's fixed small stack. Adds:
  - simultaneous push/pop;
  - a registered read port with a valid strobe;
  - an occupancy count and an almost-full flag;
  - sticky overflow/underflow error flags.
- Sits between producer and consumer logic inside datapath blocks.

Parameters:
- WIDTH, 8: data word width in bits, >=1.
- DEPTH, 8: number of entries, >=2, any integer (need not be a power of 2).
- AF_LEVEL, DEPTH-1: almost_full asserts when count >= AF_LEVEL, 1..DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  requested mode: 0 = FIFO, 1 = LIFO.
- push  in  1  write request.
- pop  in  1  read request.
- data_in  in  WIDTH  write data.
- err_clr  in  1  clears the sticky error flags.
- data_out  out  WIDTH  read data, registered.
- out_valid  out  1  data_out valid, one-cycle pulse.
- count  out  $clog2(DEPTH+1)  current occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_LEVEL.
- active_mode  out  1  mode currently in force.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (async assert, sync release):
  - count=0, empty=1, full=0, almost_full=0.
  - out_valid=0, data_out=0.
  - overflow=0, underflow=0, active_mode=0 (FIFO).
  - Storage contents are not reset. Reset mid-operation discards all entries.
- Mode:
  - active_mode loads from mode on any clock edge where empty=1 and no push is accepted that cycle.
  - Otherwise mode is ignored. A mode change never reorders stored data.
- Acceptance, evaluated per cycle:
  - pop_ok = pop & !empty.
  - push_ok = push & (!full | pop_ok).
- FIFO mode:
  - Circular write/read pointers wrap from DEPTH-1 to 0.
  - push_ok writes data_in at wr_ptr. pop_ok reads entry rd_ptr.
  - Both together: count unchanged, both pointers advance.
- LIFO mode:
  - Top index = count-1.
  - push_ok alone writes at index count, count+1.
  - pop_ok alone reads the top, count-1.
  - Both together: the old top is read, data_in overwrites the top slot, count unchanged. This is legal when full.
- Read port:
  - On pop_ok, data_out is loaded on that edge and out_valid=1 for the following cycle. Latency is 1 cycle.
  - data_out holds its value when out_valid=0.
  - A push never forwards into data_out in the same cycle.
- Empty case: push & pop while empty means push accepted, pop rejected (underflow set), out_valid stays 0.
- Errors:
  - overflow sets when push & !push_ok.
  - underflow sets when pop & !pop_ok.
  - Both are sticky until err_clr. If err_clr and a new error occur in the same cycle, the flag remains set.
  - A rejected request changes no other state.
- Flags empty, full, almost_full and count are registered and consistent with each other every cycle.
- Width rules:
  - count is exactly $clog2(DEPTH+1) bits.
  - Pointers are $clog2(DEPTH) bits, minimum 1.
  - Wrap is compare-to-DEPTH-1, not natural overflow, so non-power-of-2 depths are supported.

Decomposition:
- Shared package holds:
  - mode constants MODE_FIFO=0, MODE_LIFO=1;
  - a function computing the count width from DEPTH.
- One sub-module, buf_mem: a DEPTH x WIDTH memory with one synchronous write port and one registered read port, no reset on the array.
- Pointer/count/flag control stays in stack_queue_buf.

Test Plan (WIDTH=8, DEPTH=4, AF_LEVEL=3):
- FIFO fill then drain:
  - Push 0x11,0x22,0x33,0x44 -> full=1, count=4, almost_full from the 3rd push.
  - Pop x4 -> out_valid pulses with 0x11,0x22,0x33,0x44, each one cycle after its pop; then empty=1.
- LIFO mode:
  - mode=1 while empty; push 0xA1,0xA2,0xA3 -> active_mode=1.
  - Pop x3 -> data_out sequence 0xA3,0xA2,0xA1.
- LIFO full with simultaneous push+pop:
  - Stack full with 1,2,3,4; push 0x55 & pop together -> data_out=0x04, count stays 4, overflow=0.
  - Next pop -> 0x55.
- FIFO wrap under concurrency:
  - Run 10 cycles of push+pop at count=2 -> outputs match input order with a 2-entry lag; count stays 2 and pointers wrap cleanly.
- Errors:
  - Pop when empty -> underflow=1, out_valid=0.
  - Push when full without pop -> overflow=1, contents unchanged.
  - err_clr -> both flags 0.
- Mode lock and reset:
  - mode toggled while count=2 -> active_mode unchanged.
  - Assert rst mid-stream -> count=0, empty=1, out_valid=0 immediately, without waiting for a clock edge.
